// File: rtl/data_mem_resp.sv
// Data-memory responder for the 16-bit CPU: captures one MemRead/MemWrite request,
// waits WAIT_CYCLES, then completes it with a one-cycle ack (err on rejection).
module data_mem_resp #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [15:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              ack,
    output logic              err
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_is_wr;
    logic                r_reject;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_busy;
    logic                r_ack;
    logic                r_err;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic w_req;
    logic w_out_of_range;
    logic w_finish;
    logic w_commit;

    assign w_req          = MemRead | MemWrite;
    assign w_out_of_range = |addr[15:ADDR_W];
    assign w_finish       = (r_state == S_WAIT) && (r_cnt == 4'd0);
    // The write lands on the same edge that raises ack, so a following read sees it.
    assign w_commit       = w_finish && r_is_wr && !r_reject;

    // Storage has no reset; an aborted op never reaches w_commit because reset forces IDLE.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_is_wr  <= 1'b0;
            r_reject <= 1'b0;
            r_rdata  <= '0;
            r_busy   <= 1'b0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack <= 1'b0;
                    r_err <= 1'b0;
                    if (w_req) begin
                        r_addr   <= addr[ADDR_W-1:0];
                        r_wdata  <= wdata;
                        r_is_wr  <= MemWrite;
                        r_reject <= (MemRead & MemWrite) | w_out_of_range;
                        r_cnt    <= 4'(WAIT_CYCLES);
                        r_busy   <= 1'b1;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_ack   <= 1'b1;
                        r_err   <= r_reject;
                        if (!r_reject && !r_is_wr) begin
                            r_rdata <= r_mem[r_addr];
                        end
                    end
                end
                S_DONE: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign rdata = r_rdata;
    assign busy  = r_busy;
    assign ack   = r_ack;
    assign err   = r_err;

endmodule
